// File: rtl/voter_pkg.sv
// Shared types, constants and the bit-count helper for the N-way voter.
package voter_pkg;

    // Run-time voting mode, sampled together with each accepted sample.
    typedef enum logic {
        VOTE_MAJ = 1'b0,
        VOTE_MIN = 1'b1
    } vote_mode_e;

    // Width of the optional disagreement event counter.
    localparam int ERRCNT_W = 16;

    // Widest channel count the bit-count helper supports.
    localparam int POP_MAX = 64;

    // Number of set bits in a column of channel bits (unused upper bits must be 0).
    function automatic int unsigned popcount_n(input logic [POP_MAX-1:0] bits);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            c = c + 32'(bits[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/voter_nway_if.sv
// Handshake bundle for the N-way voter: input sample side, output word side,
// run-time mode and the fault reporting/clear signals.
//
// Handshake contract (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high; valid, once raised, and its data stay
// stable until that transfer; ready may depend combinationally on the
// consumer's ready but never on the producer's valid.
interface voter_nway_if #(
    parameter int N = 3,
    parameter int W = 4
);
    logic           mode;
    logic [N*W-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           clear_fault;
    logic [N-1:0]   fault;

    // Producer / consumer side of the voter.
    modport master (
        output mode, in_data, in_valid, out_ready, clear_fault,
        input  in_ready, out_data, out_valid, fault
    );

    // The voter itself.
    modport slave (
        input  mode, in_data, in_valid, out_ready, clear_fault,
        output in_ready, out_data, out_valid, fault
    );
endinterface

// File: rtl/voter_fault_tracker.sv
// Per-channel disagreement tracker: counts consecutive accepted samples in
// which the channel disagreed with the majority word and raises a sticky
// fault flag once FAULT_LIMIT such samples have been seen in a row.
module voter_fault_tracker #(
    parameter int FAULT_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    input  logic disagree,
    input  logic clear_fault,
    output logic fault
);
    localparam int CW = $clog2(FAULT_LIMIT + 1);

    logic [CW-1:0] count;

    // Saturating run counter and sticky flag; clear beats a same-cycle update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            fault <= 1'b0;
        end else if (clear_fault) begin
            count <= '0;
            fault <= 1'b0;
        end else if (accept) begin
            if (disagree) begin
                if (count != CW'(FAULT_LIMIT)) begin
                    count <= count + 1'b1;
                end
                // The flag sets on the sample that brings the run to the limit.
                if (count >= CW'(FAULT_LIMIT - 1)) begin
                    fault <= 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end
endmodule

// File: rtl/voter_nway.sv
// Registered N-channel bitwise majority/minority voter with a one-deep
// valid/ready output register and per-channel fault trackers.
// Optional build macro VOTER_ERRCNT_EN adds err_count, a saturating count of
// accepted samples in which any channel disagreed with the majority word.
module voter_nway
    import voter_pkg::*;
#(
    parameter int N           = 3,
    parameter int W           = 4,
    parameter int FAULT_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    voter_nway_if.slave         bus
`ifdef VOTER_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);
    localparam int CNT_W = $clog2(N + 1);

    // Parameter sanity: odd channel count means the vote never ties.
    if (N < 3 || (N % 2) == 0) begin : g_bad_n
        $error("voter_nway: N must be odd and >= 3");
    end
    if (N > POP_MAX) begin : g_big_n
        $error("voter_nway: N exceeds popcount_n capacity");
    end
    if (FAULT_LIMIT < 1) begin : g_bad_limit
        $error("voter_nway: FAULT_LIMIT must be >= 1");
    end

    logic [W-1:0]       maj_word;
    logic [W-1:0]       vote_word;
    logic [N-1:0]       disagree;
    logic [N-1:0]       fault_w;
    logic [POP_MAX-1:0] col;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               in_ready_w;
    logic [W-1:0]       out_data_q;
    logic               out_valid_q;
    vote_mode_e         mode_w;

    assign mode_w     = vote_mode_e'(bus.mode);
    assign in_ready_w = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_w;

    // Per-bit vote: gather column b across channels and compare its count with N/2.
    always_comb begin
        maj_word = '0;
        col      = '0;
        cnt      = '0;
        for (int b = 0; b < W; b++) begin
            col = '0;
            for (int i = 0; i < N; i++) begin
                col[i] = bus.in_data[i*W + b];
            end
            cnt         = CNT_W'(popcount_n(col));
            maj_word[b] = (cnt > CNT_W'(N / 2));
        end
    end

    // Output word follows the selected mode; trackers always use the majority.
    always_comb begin
        vote_word = (mode_w == VOTE_MIN) ? ~maj_word : maj_word;
        disagree  = '0;
        for (int i = 0; i < N; i++) begin
            disagree[i] = (bus.in_data[i*W +: W] != maj_word);
        end
    end

    // One-deep output register: load on accept, drop valid when drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_data_q  <= vote_word;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_track
        voter_fault_tracker #(
            .FAULT_LIMIT(FAULT_LIMIT)
        ) u_track (
            .clk        (clk),
            .reset      (reset),
            .accept     (accept),
            .disagree   (disagree[g]),
            .clear_fault(bus.clear_fault),
            .fault      (fault_w[g])
        );
    end

`ifdef VOTER_ERRCNT_EN
    // Saturating count of accepted samples with any disagreeing channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (bus.clear_fault) begin
            err_count <= '0;
        end else if (accept && (|disagree) && (err_count != {ERRCNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fault     = fault_w;
endmodule

// File: tb/tb_voter_nway.sv
// Directed bench for voter_nway (N=3, W=4, FAULT_LIMIT=4).
module tb_voter_nway;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    voter_nway_if #(.N(3), .W(4)) bus ();

`ifdef VOTER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    voter_nway #(
        .N(3),
        .W(4),
        .FAULT_LIMIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
`ifdef VOTER_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample for exactly one edge (caller ensures in_ready is high).
    task automatic send(input logic [3:0] c0, input logic [3:0] c1,
                        input logic [3:0] c2, input logic m);
        bus.in_data  = {c2, c1, c0};
        bus.mode     = m;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] min_tab;
        logic [2:0] kb;
        total           = 0;
        bad             = 0;
        min_tab         = 8'b0001_0111;
        reset           = 1'b1;
        bus.mode        = 1'b0;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        bus.clear_fault = 1'b0;
        #12;
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Exhaustive per-bit vote, minority then majority
        for (int k = 0; k < 8; k++) begin
            kb = k[2:0];
            send({4{kb[0]}}, {4{kb[1]}}, {4{kb[2]}}, 1'b1);
            check("min_data", bus.out_data, {28'd0, {4{min_tab[k]}}});
            check("min_valid", bus.out_valid, 1);
        end
        for (int k = 0; k < 8; k++) begin
            kb = k[2:0];
            send({4{kb[0]}}, {4{kb[1]}}, {4{kb[2]}}, 1'b0);
            check("maj_data", bus.out_data, {28'd0, {4{~min_tab[k]}}});
        end
        tick();
        check("drain_valid", bus.out_valid, 0);
        check("exh_fault", bus.fault, 0);

        // Backpressure and no-bubble reload
        bus.out_ready = 1'b0;
        send(4'hA, 4'hA, 4'h5, 1'b0);
        check("bp_first", bus.out_data, 4'hA);
        bus.in_data  = {4'h3, 4'h3, 4'h3};
        bus.in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("bp_hold_data", bus.out_data, 4'hA);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.in_ready, 1);
        tick();
        check("bp_reload_data", bus.out_data, 4'h3);
        check("bp_reload_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        tick();
        check("bp_drained", bus.out_valid, 0);

        // Fault flag after FAULT_LIMIT consecutive disagreements of ch2
        send(4'h6, 4'h6, 4'h7, 1'b0);
        send(4'h6, 4'h6, 4'h7, 1'b0);
        send(4'h6, 4'h6, 4'h7, 1'b0);
        check("flt_before_limit", bus.fault, 0);
        send(4'h6, 4'h6, 4'h7, 1'b0);
        check("flt_at_limit", bus.fault, 3'b100);
        send(4'h6, 4'h6, 4'h6, 1'b0);
        check("flt_sticky", bus.fault, 3'b100);

        // Clear with same-cycle accept: clear wins, data still produced
        bus.clear_fault = 1'b1;
        send(4'h6, 4'h6, 4'h7, 1'b0);
        bus.clear_fault = 1'b0;
        check("clr_fault", bus.fault, 0);
        check("clr_data", bus.out_data, 4'h6);
        check("clr_valid", bus.out_valid, 1);
        send(4'h6, 4'h6, 4'h7, 1'b0);
        send(4'h6, 4'h6, 4'h7, 1'b0);
        send(4'h6, 4'h6, 4'h7, 1'b0);
        check("clr_sample_dropped", bus.fault, 0);
        send(4'h6, 4'h6, 4'h7, 1'b0);
        check("clr_then_limit", bus.fault, 3'b100);
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        check("clr_alone", bus.fault, 0);

        // Run counter restarts on an agreeing sample
        send(4'h5, 4'hA, 4'h5, 1'b0);
        send(4'h5, 4'hA, 4'h5, 1'b0);
        send(4'h5, 4'hA, 4'h5, 1'b0);
        send(4'h5, 4'h5, 4'h5, 1'b0);
        send(4'h5, 4'hA, 4'h5, 1'b0);
        send(4'h5, 4'hA, 4'h5, 1'b0);
        send(4'h5, 4'hA, 4'h5, 1'b0);
        check("run_reset_fault", bus.fault, 0);
        check("run_reset_data", bus.out_data, 4'h5);

        // Multi-bit minority words
        send(4'hA, 4'hA, 4'h5, 1'b1);
        check("min_word_a", bus.out_data, 4'h5);
        send(4'hC, 4'hC, 4'h3, 1'b1);
        check("min_word_c", bus.out_data, 4'h3);

        // Held output is not recomputed on a mode change
        tick();
        bus.out_ready = 1'b0;
        send(4'hC, 4'hC, 4'h3, 1'b0);
        bus.mode = 1'b1;
        tick();
        tick();
        check("mode_hold_data", bus.out_data, 4'hC);
        check("mode_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        check("mode_hold_drain", bus.out_valid, 0);

        // Async reset while an output is pending and a fault is set
        send(4'h1, 4'h2, 4'h2, 1'b0);
        send(4'h1, 4'h2, 4'h2, 1'b0);
        send(4'h1, 4'h2, 4'h2, 1'b0);
        send(4'h1, 4'h2, 4'h2, 1'b0);
        check("pre_rst_fault", bus.fault, 3'b001);
        tick();
        bus.out_ready = 1'b0;
        send(4'h1, 4'h2, 4'h2, 1'b0);
        check("pre_rst_valid", bus.out_valid, 1);
        check("pre_rst_data", bus.out_data, 4'h2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_data", bus.out_data, 0);
        check("arst_fault", bus.fault, 0);
        check("arst_in_ready", bus.in_ready, 1);
`ifdef VOTER_ERRCNT_EN
        check("arst_err_count", err_count, 0);
`endif
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_valid", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
